// File: rtl/hazard_ctrl.sv
// Stall/flush control for the 5-stage pipeline plus the mult/div busy sequencer.
// Hazard outputs are combinational in the decode cycle; md_done is a registered pulse.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       usersD,
  input  logic       usertD,
  input  logic       branchD,
  input  logic       branch_takenD,
  input  logic       mdopD,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic [4:0] writeregE,
  input  logic       memtoregM,
  input  logic [4:0] writeregM,
  input  logic       mdstartE,
  input  logic       mdisdivE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       clearE,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [7:0] MULT_LAST = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LAST  = 8'(DIV_CYCLES - 1);

  md_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  logic rs_hitE, rt_hitE, rs_hitM, rt_hitM;
  logic lwstall, brstall, mdstall, stall, busy;

  // Register 0 is hardwired, so it never forms a dependency.
  assign rs_hitE = usersD && (rsD != 5'd0) && (rsD == writeregE);
  assign rt_hitE = usertD && (rtD != 5'd0) && (rtD == writeregE);
  assign rs_hitM = usersD && (rsD != 5'd0) && (rsD == writeregM);
  assign rt_hitM = usertD && (rtD != 5'd0) && (rtD == writeregM);

  assign busy    = (state_q == BUSY);
  assign lwstall = memtoregE && (rs_hitE || rt_hitE);
  assign brstall = branchD && ((regwriteE && (rs_hitE || rt_hitE)) ||
                               (memtoregM && (rs_hitM || rt_hitM)));
  assign mdstall = mdopD && (busy || mdstartE);
  assign stall   = lwstall || brstall || mdstall;

  // Reset squashes both front registers and keeps the PC free to reload.
  assign stallF  = stall && !rst;
  assign stallD  = stall && !rst;
  assign clearE  = stall || rst;
  assign flushD  = (branch_takenD && !stall) || rst;
  assign md_busy = busy && !rst;
  assign md_done = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdstartE) begin
          state_d = BUSY;
          cnt_d   = mdisdivE ? DIV_LAST : MULT_LAST;
        end
      end
      BUSY: begin
        // A start seen here is an illegal overlap and is deliberately dropped.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized check of hazard_ctrl against a remaining-cycles model.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, writeregE, writeregM;
  logic       usersD, usertD, branchD, branch_takenD, mdopD;
  logic       regwriteE, memtoregE, memtoregM, mdstartE, mdisdivE;
  logic       stallF, stallD, flushD, clearE, md_busy, md_done;

  int ncmp  = 0;
  int nfail = 0;

  // Model state: busy cycles still to run (incl. current) and pending done pulse.
  int   m_rem  = 0;
  logic m_done = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .usersD(usersD), .usertD(usertD),
    .branchD(branchD), .branch_takenD(branch_takenD), .mdopD(mdopD),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .writeregE(writeregE),
    .memtoregM(memtoregM), .writeregM(writeregM),
    .mdstartE(mdstartE), .mdisdivE(mdisdivE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .clearE(clearE),
    .md_busy(md_busy), .md_done(md_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic dep(input logic use_r, input logic [4:0] r, input logic [4:0] w);
    return use_r && (r != 0) && (r == w);
  endfunction

  task automatic check_model(input string tag);
    logic lw, br, md, st;
    lw = memtoregE && (dep(usersD, rsD, writeregE) || dep(usertD, rtD, writeregE));
    br = branchD && ((regwriteE && (dep(usersD, rsD, writeregE) || dep(usertD, rtD, writeregE))) ||
                     (memtoregM && (dep(usersD, rsD, writeregM) || dep(usertD, rtD, writeregM))));
    md = mdopD && ((m_rem > 0) || mdstartE);
    st = lw || br || md;
    if (rst) begin
      chk({tag, ".stallF"},  stallF,  1'b0);
      chk({tag, ".stallD"},  stallD,  1'b0);
      chk({tag, ".flushD"},  flushD,  1'b1);
      chk({tag, ".clearE"},  clearE,  1'b1);
      chk({tag, ".md_busy"}, md_busy, 1'b0);
    end else begin
      chk({tag, ".stallF"},  stallF,  st);
      chk({tag, ".stallD"},  stallD,  st);
      chk({tag, ".flushD"},  flushD,  branch_takenD && !st);
      chk({tag, ".clearE"},  clearE,  st);
      chk({tag, ".md_busy"}, md_busy, m_rem > 0);
    end
    chk({tag, ".md_done"}, md_done, m_done);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_rem = 0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--; m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (mdstartE) m_rem = mdisdivE ? DIV_N : MULT_N;
    end
  endtask

  // Inputs are set at negedge; check after settling, then advance one clock.
  task automatic cycle(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; rsD = 0; rtD = 0; usersD = 0; usertD = 0; branchD = 0;
    branch_takenD = 0; mdopD = 0; regwriteE = 0; memtoregE = 0;
    writeregE = 0; memtoregM = 0; writeregM = 0; mdstartE = 0; mdisdivE = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); model_edge(); @(negedge clk);
    #1;
    chk("reset.flushD", flushD, 1'b1);
    chk("reset.clearE", clearE, 1'b1);
    chk("reset.stallF", stallF, 1'b0);
    chk("reset.md_busy", md_busy, 1'b0);
    chk("reset.md_done", md_done, 1'b0);
    cycle("reset");
    rst = 0;

    // Load-use on rs, then load moves to M.
    memtoregE = 1; writeregE = 8; rsD = 8; usersD = 1;
    #1 chk("loaduse.stall", stallD, 1'b1);
    cycle("loaduse");
    memtoregE = 0; memtoregM = 1; writeregM = 8;
    #1 chk("loaduse_next.stall", stallD, 1'b0);
    cycle("loaduse_next");

    idle_inputs();
    memtoregE = 1; writeregE = 0; rsD = 0; usersD = 1;
    #1 chk("zero_reg.stall", stallF, 1'b0);
    cycle("zero_reg");
    writeregE = 8; rsD = 8; usersD = 0;
    #1 chk("unused_rs.stall", stallF, 1'b0);
    cycle("unused_rs");

    // Branch compare operand still in E: stall beats flush.
    idle_inputs();
    branchD = 1; regwriteE = 1; writeregE = 5; rtD = 5; usertD = 1; branch_takenD = 1;
    #1 chk("branch.stall", clearE, 1'b1);
    chk("branch.flushD", flushD, 1'b0);
    cycle("branch");
    writeregE = 9;
    #1 chk("branch_next.flushD", flushD, 1'b1);
    cycle("branch_next");

    // Multiply with a dependent HI/LO reader held in D.
    idle_inputs();
    mdopD = 1; mdstartE = 1; mdisdivE = 0;
    cycle("mult_issue");
    mdstartE = 0;
    for (int i = 1; i <= MULT_N; i++) begin
      #1 chk("mult.busy", md_busy, 1'b1);
      chk("mult.stall", stallD, 1'b1);
      cycle("mult_busy");
    end
    #1 chk("mult.done", md_done, 1'b1);
    chk("mult.release", stallD, 1'b0);
    cycle("mult_done");
    mdopD = 0;
    cycle("mult_after");

    // Divide then multiply issued in the md_done cycle.
    mdstartE = 1; mdisdivE = 1;
    cycle("div_issue");
    mdstartE = 0;
    for (int i = 0; i < DIV_N; i++) cycle("div_busy");
    #1 chk("div.done", md_done, 1'b1);
    mdstartE = 1; mdisdivE = 0;
    cycle("b2b_issue");
    mdstartE = 0;
    for (int i = 0; i < MULT_N; i++) cycle("b2b_busy");
    #1 chk("b2b.done", md_done, 1'b1);
    cycle("b2b_done");

    // Reset while divide counter reads 3 (seventh busy cycle).
    mdstartE = 1; mdisdivE = 1;
    cycle("rdiv_issue");
    mdstartE = 0;
    for (int i = 0; i < 6; i++) cycle("rdiv_busy");
    rst = 1;
    #1 chk("rst_mid.stallF", stallF, 1'b0);
    chk("rst_mid.clearE", clearE, 1'b1);
    chk("rst_mid.flushD", flushD, 1'b1);
    cycle("rst_mid");
    rst = 0;
    #1 chk("rst_after.busy", md_busy, 1'b0);
    chk("rst_after.done", md_done, 1'b0);
    for (int i = 0; i < 8; i++) cycle("rst_after");

    // Randomized traffic; narrow register range to provoke matches.
    for (int n = 0; n < 2000; n++) begin
      rst           = ($urandom_range(0, 59) == 0);
      rsD           = 5'($urandom_range(0, 3));
      rtD           = 5'($urandom_range(0, 3));
      writeregE     = 5'($urandom_range(0, 3));
      writeregM     = 5'($urandom_range(0, 3));
      usersD        = 1'($urandom);
      usertD        = 1'($urandom);
      branchD       = 1'($urandom);
      branch_takenD = 1'($urandom);
      mdopD         = ($urandom_range(0, 3) == 0);
      regwriteE     = 1'($urandom);
      memtoregE     = 1'($urandom);
      memtoregM     = 1'($urandom);
      mdstartE      = ($urandom_range(0, 7) == 0);
      mdisdivE      = 1'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
